// File: rtl/proc_pkg.sv
// Shared types and constants for the pixel processing controller.
// Holds pixel sizes, job mode encodings and the controller FSM state enum.
package proc_pkg;

  localparam int COLOR_SIZE = 8;
  localparam int PIXEL_SIZE = 24;

  localparam logic [1:0] MODE_NONE   = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_BRIGHT = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  function automatic logic mode_ok(input logic [1:0] m);
    return (m == MODE_THRESH) || (m == MODE_BRIGHT);
  endfunction

endpackage

// File: rtl/proc_out_fifo.sv
// First-word-fall-through output buffer for processed words.
// Ports: push/push_data in, pop/pop_data/empty out, count = occupancy.
module proc_out_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot this cycle.
  assign do_push  = push && ((count != CW'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/proc_controller.sv
// Streams a job of pixel words to a fixed-latency processor and buffers results.
// Ports: start/cfg_* job request, src_* input, proc_* processor link, dst_* output.
module proc_controller
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [COLOR_SIZE-1:0] cfg_proc_val,
  input  logic [CNT_WIDTH-1:0]  cfg_num_words,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_vld,
  output logic                  src_rdy,
  output logic                  proc_vld,
  output logic                  proc_last,
  output logic [1:0]            proc_mode,
  output logic [COLOR_SIZE-1:0] proc_val,
  output logic [DATA_WIDTH-1:0] proc_data,
  input  logic [DATA_WIDTH-1:0] proc_out_data,
  input  logic                  proc_out_vld,
  input  logic                  proc_done,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  dst_vld,
  input  logic                  dst_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 done_seen;
  logic                 start_ok;
  logic                 start_bad;
  logic                 credit_ok;
  logic                 xfer;
  logic                 push;
  logic                 stray;

  assign start_ok  = (state == IDLE) && start &&
                     mode_ok(cfg_mode) && (cfg_num_words != '0);
  assign start_bad = (state == IDLE) && start && !start_ok;

  // Processor cannot stall, so every word sent needs a reserved FIFO slot.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight})
                     < (CW+1)'(FIFO_DEPTH);

  assign xfer      = src_vld && src_rdy;
  assign proc_vld  = xfer;
  assign proc_data = src_data;
  assign proc_last = xfer && (word_cnt == num_q - 1'b1);

  assign push  = proc_out_vld && (inflight != '0);
  assign stray = proc_out_vld && (inflight == '0);

  assign dst_vld = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_ok) state_nxt = STREAM;
      STREAM: if (proc_last) state_nxt = DRAIN;
      DRAIN:  if ((done_seen || proc_done) &&
                  (inflight == '0) && fifo_empty)
                state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_rdy = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE:   busy    = 1'b0;
      STREAM: src_rdy = credit_ok;
      DRAIN:  ;
      FINISH: done    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_mode <= '0;
      proc_val  <= '0;
      num_q     <= '0;
      word_cnt  <= '0;
      inflight  <= '0;
      done_seen <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= start_bad || stray;
      if (start_ok) begin
        proc_mode <= cfg_mode;
        proc_val  <= cfg_proc_val;
        num_q     <= cfg_num_words;
        word_cnt  <= '0;
        inflight  <= '0;
        done_seen <= 1'b0;
      end else begin
        if (xfer) word_cnt <= word_cnt + 1'b1;
        if (proc_done && (state != IDLE)) done_seen <= 1'b1;
        if (xfer && !push)      inflight <= inflight + 1'b1;
        else if (push && !xfer) inflight <= inflight - 1'b1;
      end
    end
  end

  proc_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (proc_out_data),
    .pop       (dst_rdy),
    .pop_data  (dst_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_proc_controller.sv
// Self-checking bench for proc_controller with a 1-cycle processor model.
// Drives random pixel jobs and compares against a queue-based reference.
module tb_proc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_proc_val = '0;
  logic [15:0] cfg_num_words = '0;
  logic [31:0] src_data = '0;
  logic        src_vld = 1'b0;
  logic        src_rdy;
  logic        proc_vld;
  logic        proc_last;
  logic [1:0]  proc_mode;
  logic [7:0]  proc_val;
  logic [31:0] proc_data;
  logic [31:0] proc_out_data;
  logic        proc_out_vld;
  logic        proc_done;
  logic [31:0] dst_data;
  logic        dst_vld;
  logic        dst_rdy = 1'b1;
  logic        busy;
  logic        done;
  logic        err;

  logic        pv_q;
  logic [31:0] pd_q;
  logic        pdone_q;
  logic        inj = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          t0;
  int          tdone;

  proc_controller #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_mode      (cfg_mode),
    .cfg_proc_val  (cfg_proc_val),
    .cfg_num_words (cfg_num_words),
    .src_data      (src_data),
    .src_vld       (src_vld),
    .src_rdy       (src_rdy),
    .proc_vld      (proc_vld),
    .proc_last     (proc_last),
    .proc_mode     (proc_mode),
    .proc_val      (proc_val),
    .proc_data     (proc_data),
    .proc_out_data (proc_out_data),
    .proc_out_vld  (proc_out_vld),
    .proc_done     (proc_done),
    .dst_data      (dst_data),
    .dst_vld       (dst_vld),
    .dst_rdy       (dst_rdy),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pix_fn(input logic [1:0] m,
                                         input logic [7:0] v,
                                         input logic [31:0] d);
    logic [31:0] r;
    int s;
    r = d;
    for (int b = 0; b < 4; b++) begin
      s = int'(d[8*b +: 8]);
      if (m == 2'd2)
        r[8*b +: 8] = (s + int'(v) > 255) ? 8'hFF : 8'(s + int'(v));
      else if (m == 2'd1)
        r[8*b +: 8] = (s >= int'(v)) ? 8'hFF : 8'h00;
    end
    return r;
  endfunction

  // Processor model: one cycle latency, done follows the last word out.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q    <= 1'b0;
      pd_q    <= '0;
      pdone_q <= 1'b0;
    end else begin
      pv_q    <= proc_vld;
      pd_q    <= pix_fn(proc_mode, proc_val, proc_data);
      pdone_q <= proc_vld && proc_last;
    end
  end

  assign proc_out_vld  = pv_q | inj;
  assign proc_out_data = pd_q;
  assign proc_done     = pdone_q;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [1:0] m, input logic [7:0] v,
                         input int n, input int stall, input bit rnd,
                         input int bstart, input int rst_after);
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    int idx = 0;
    int oi = 0;
    bit fin = 0;
    bit pend = 0;
    logic [2:0] pc = '0;
    for (int i = 0; i < n; i++) begin
      src_q.push_back($urandom);
      exp_q.push_back(pix_fn(m, v, src_q[i]));
    end
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = m; cfg_proc_val = v;
    cfg_num_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    for (int c = 0; c < 4000 && !fin; c++) begin
      src_vld  = (idx < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      src_data = (idx < n) ? src_q[idx] : $urandom;
      dst_rdy  = (c < stall) ? 1'b0 :
                 (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      start    = (c == bstart);
      cfg_mode = (m == 2'd1) ? 2'd2 : 2'd1;
      cfg_proc_val = ~v;
      cfg_num_words = 16'd5;
      @(negedge clk);
      if (bstart >= 0 && c == bstart + 1) begin
        chk("busy_start_mode", proc_mode, m);
        chk("busy_start_val", proc_val, v);
      end
      if (pend) chk("push_pop_count", dut.u_fifo.count, pc);
      pend = proc_out_vld && dst_vld && dst_rdy;
      pc = dut.u_fifo.count;
      if (dut.u_fifo.count > 3'd4) chk("fifo_overflow", dut.u_fifo.count, 4);
      if (proc_vld) begin
        chk("proc_data", proc_data, src_q[idx]);
        chk("proc_last", proc_last, idx == n - 1);
        idx++;
      end
      if (stall > 0 && c == stall - 1) begin
        chk("bp_xfers", idx, 4);
        chk("bp_src_rdy", src_rdy, 0);
      end
      if (dst_vld && dst_rdy) begin
        chk("dst_data", dst_data, (oi < n) ? exp_q[oi] : 32'hx);
        oi++;
      end
      if (done) begin
        fin = 1;
        tdone = cyc;
      end
      if (rst_after >= 0 && idx == rst_after) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_src_rdy", src_rdy, 0);
        chk("rst_proc_vld", proc_vld, 0);
        chk("rst_proc_last", proc_last, 0);
        chk("rst_mode_val", {proc_mode, proc_val}, 0);
        chk("rst_dst_vld", dst_vld, 0);
        src_vld = 1'b0;
        dst_rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_done", done, 0);
        return;
      end
      @(posedge clk); #1;
    end
    src_vld = 1'b0;
    dst_rdy = 1'b1;
    start = 1'b0;
    chk("job_done", fin, 1);
    chk("words_in", idx, n);
    chk("words_out", oi, n);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic bad_start(input logic [1:0] m, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = m; cfg_num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_proc_vld", proc_vld, 0);
    @(negedge clk);
    chk("bad_err_off", err, 0);
    chk("bad_busy2", busy, 0);
  endtask

  initial begin
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_outs", {done, err, src_rdy, proc_vld, proc_last, dst_vld}, 0);
    chk("reset_cfg", {proc_mode, proc_val}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(2'd2, 8'h10, 8, 0, 0, -1, -1);
    run_job(2'd1, 8'h80, 16, 20, 0, -1, -1);
    bad_start(2'd0, 16'd4);
    bad_start(2'd3, 16'd4);
    bad_start(2'd1, 16'd0);
    run_job(2'd1, 8'h40, 10, 0, 0, 3, -1);
    run_job(2'd2, 8'h05, 10, 0, 0, -1, 3);
    run_job(2'd1, 8'h22, 2, 0, 0, -1, -1);
    run_job(2'd2, 8'h30, 1, 0, 0, -1, -1);
    chk("min_latency", (tdone - t0) >= 4, 1);

    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    chk("stray_err", err, 1);
    chk("stray_dst_vld", dst_vld, 0);

    for (int j = 0; j < 6; j++)
      run_job(2'($urandom_range(1, 2)), 8'($urandom),
              $urandom_range(1, 20), 0, 1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_controller.md
PROC_CONTROLLER -- requirements
Module: proc_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the pixel-word width (32 or 64).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the width of the word count.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the output buffer depth (power of 2, at least 2).
REQ-004 clk  in  1  single clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle job request.
REQ-007 cfg_mode  in  2  job mode: 1 = threshold, 2 = brightness.
REQ-008 cfg_proc_val  in  8  threshold or brightness value.
REQ-009 cfg_num_words  in  CNT_WIDTH  number of words in the job.
REQ-010 src_data  in  DATA_WIDTH  input pixel word.
REQ-011 src_vld  in  1 / src_rdy  out  1  input handshake.
REQ-012 proc_vld, proc_last  out  1 each; proc_mode  out  2; proc_val  out  8; proc_data  out  DATA_WIDTH  drive to the processor.
REQ-013 proc_out_data  in  DATA_WIDTH; proc_out_vld  in  1; proc_done  in  1  returns from the processor.
REQ-014 dst_data  out  DATA_WIDTH; dst_vld  out  1; dst_rdy  in  1  output handshake.
REQ-015 busy  out  1; done  out  1 (pulse); err  out  1 (pulse).

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, DRAIN and FINISH.
REQ-017 IDLE: start with cfg_mode in {1,2} and cfg_num_words != 0 -> latch the config, clear counters, go to STREAM next cycle.
REQ-018 IDLE: start with mode 0 or 3, or with cfg_num_words == 0 -> err high for one cycle, stay in IDLE, no proc_vld.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 proc_mode and proc_val SHALL hold the latched config from the STREAM entry cycle until the return to IDLE.
REQ-022 A word transfers in STREAM when src_vld && src_rdy.
REQ-023 src_rdy SHALL be asserted only in STREAM when (fifo_count + inflight) < FIFO_DEPTH; this credit rule guarantees the FIFO never overflows, because the processor has no backpressure.
REQ-024 proc_vld SHALL equal the transfer condition, combinationally.
REQ-025 proc_data SHALL equal src_data, combinationally.
REQ-026 proc_last SHALL be 1 on the transfer of word cfg_num_words-1; on that transfer the FSM goes to DRAIN.
REQ-027 inflight SHALL increment on each proc_vld, decrement on each proc_out_vld, and hold when both occur in the same cycle.
REQ-028 proc_out_vld SHALL push proc_out_data into the FIFO.
REQ-029 The FIFO SHALL be first-word-fall-through: dst_vld = !empty, and a pop occurs on dst_vld && dst_rdy.
REQ-030 A simultaneous push and pop SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-031 DRAIN -> FINISH when proc_done has been seen (sticky flag), inflight == 0 and the FIFO is empty.
REQ-032 FINISH SHALL assert done for one cycle, then return to IDLE.
REQ-033 Minimum job time: 1-word job with processor latency L and dst_rdy held at 1 -> done at least L+3 cycles after start.
REQ-034 The word counter SHALL be CNT_WIDTH bits and SHALL never wrap; a job of 2^CNT_WIDTH-1 words SHALL be legal.
REQ-035 proc_out_vld arriving while inflight == 0 SHALL be dropped and SHALL pulse err; inflight SHALL not underflow.

Reset
REQ-036 rst SHALL force, asynchronously: state IDLE; busy, done, err, src_rdy, proc_vld and proc_last at 0; proc_mode and proc_val at 0; counters and inflight at 0; FIFO empty (dst_vld 0).
REQ-037 rst mid-job SHALL abandon the job with no done pulse; the next start after rst falls is accepted normally.

Structure
REQ-038 A shared package proc_pkg SHALL hold COLOR_SIZE=8, PIXEL_SIZE=24, the mode encodings MODE_NONE/MODE_THRESH/MODE_BRIGHT/MODE_RSVD, and the FSM state enum.
REQ-039 The FIFO SHALL be the sub-module proc_out_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH, with count output.

Verification
REQ-040 Brightness job: start with mode 2, val 8'h10, 8 words, dst_rdy=1, processor model latency 1 -> 8 dst words in order, proc_last on word 7, one done pulse, busy falls the cycle after done.
REQ-041 Backpressure: 16-word threshold job, dst_rdy=0 for 20 cycles -> src_rdy falls after 4 transfers, no FIFO overflow, all 16 words delivered after release.
REQ-042 Illegal start: mode 0, mode 3, and num_words 0 -> err pulse each, busy stays 0, proc_vld never asserted.
REQ-043 Start while busy: start pulsed during STREAM with different cfg -> ignored; proc_mode and proc_val unchanged.
REQ-044 Reset mid-job: rst asserted after 3 of 10 words -> all outputs 0 immediately; new 2-word job completes with done.
REQ-045 Simultaneous push/pop with FIFO full and dst_rdy=1 -> fifo_count stays 4, data order preserved.
